// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg
//   Shared definitions for the RV32M/RV64M multiply/divide unit:
//   M-extension funct3 codes, the FSM state encoding and the operand
//   magnitude helper used for signed multiply and divide.
package riscv_muldiv_pkg;

  // M-extension funct3 codes (funct7 = 0000001 is decoded upstream)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Widest XLEN the magnitude helper supports; callers sign- or zero-extend
  // their operand to this width and keep the low XLEN bits of the result.
  localparam int MAX_XLEN = 128;

  // Two's-complement magnitude. The magnitude of the most negative XLEN
  // value is 1<<(XLEN-1), which still fits in XLEN unsigned bits.
  function automatic logic [MAX_XLEN-1:0] abs_val(input logic [MAX_XLEN-1:0] v);
    return v[MAX_XLEN-1] ? -v : v;
  endfunction

endpackage

// File: rtl/riscv_div_step.sv
// riscv_div_step
//   One combinational restoring-divide iteration. The partial remainder is
//   shifted left taking in the next dividend bit (MSB of quo), the divisor
//   is trial-subtracted, and the new quotient bit is shifted into quo.
// Ports
//   rem       in   XLEN+1  current partial remainder
//   quo       in   XLEN    dividend bits still to consume / quotient so far
//   divisor   in   XLEN    divisor magnitude
//   rem_next  out  XLEN+1  partial remainder after this step
//   quo_next  out  XLEN    quotient after this step
module riscv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {2'b00, divisor};

  // Negative difference: restore (keep the shifted remainder), quotient bit 0
  assign rem_next = diff[XLEN+1] ? shifted[XLEN:0] : diff[XLEN:0];
  assign quo_next = {quo[XLEN-2:0], ~diff[XLEN+1]};

endmodule

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
//   Iterative RV32M/RV64M multiply/divide execute unit. Multiplies use a
//   shift-add over operand magnitudes (one multiplier bit per cycle, 2*XLEN
//   accumulator); divides use a restoring divider (one quotient bit per
//   cycle). Signs are applied when leaving the iterative state. Divide by
//   zero and signed overflow bypass the iteration and finish in one cycle.
//
//   Optional build macro MULDIV_FAST_MUL_EN: when defined, multiplies use a
//   single combinational product and complete in one cycle (ST_MUL unused).
//   Division is always iterative.
//
// Handshake: a request transfers on a rising edge with in_valid && in_ready
//   && !flush; a result transfers on a rising edge with out_valid &&
//   out_ready && !flush. result is held while out_valid && !out_ready.
//
// Ports
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous active-high reset
//   in_valid   in   1     request valid
//   in_ready   out  1     unit idle, can accept a request
//   funct3     in   3     M-extension operation
//   op_a       in   XLEN  rs1 value
//   op_b       in   XLEN  rs2 value
//   flush      in   1     synchronous abort, highest priority
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer takes result
//   result     out  XLEN  result
//   busy       out  1     iterating (MUL or DIV), for hazard stall
//   state_dbg  out  2     current FSM state encoding
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  localparam int PAD = MAX_XLEN - XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;

  logic [2:0]        f3_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;      // {partial sum, remaining multiplier bits}
  logic [XLEN-1:0]   mcand;
  logic              neg_q;    // product / quotient sign
  logic              rneg_q;   // remainder sign (dividend sign)
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   result_q;

  // ---------------- request decode ----------------
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special, start_done;
  logic [XLEN-1:0] special_res;

  assign a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                 (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign b_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign a_neg = a_sgn & op_a[XLEN-1];
  assign b_neg = b_sgn & op_b[XLEN-1];
  assign a_mag = XLEN'(abs_val({{PAD{a_neg}}, op_a}));
  assign b_mag = XLEN'(abs_val({{PAD{b_neg}}, op_b}));

  assign div_zero = (op_b == '0);
  // Only signed ops (DIV, REM: funct3[0]=0) can overflow
  assign div_ovf  = !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
  assign special  = funct3[2] && (div_zero || div_ovf);

  // funct3[1] selects remainder over quotient
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3[1] ? op_a : '1;
    else          special_res = funct3[1] ? '0 : op_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN+1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;
  assign fast_prod = $signed({{(XLEN+2){a_neg}}, op_a}) *
                     $signed({{(XLEN+2){b_neg}}, op_b});
  assign fast_res  = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0]
                                        : fast_prod[2*XLEN-1:XLEN];
  assign start_done = special || !funct3[2];
`else
  assign start_done = special;
`endif

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] acc_next, mul_prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     rem_next;
  logic [XLEN-1:0]   quo_next, q_fin, r_fin, div_res;
  logic              last;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
  assign acc_next = {mul_sum, acc[XLEN-1:1]};
  assign mul_prod = neg_q ? -acc_next : acc_next;
  assign mul_res  = (f3_q == F3_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  riscv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_fin   = neg_q  ? -quo_next : quo_next;
  assign r_fin   = rneg_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
  assign div_res = f3_q[1] ? r_fin : q_fin;

  // The exit sign is applied on the edge of the final iteration
  assign last = (cnt == CNT_W'(XLEN - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (in_valid) state_next = start_done ? ST_DONE
                                        : (funct3[2] ? ST_DIV : ST_MUL);
      ST_MUL:  if (last) state_next = ST_DONE;
      ST_DIV:  if (last) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_MUL) || (state == ST_DIV);
    state_dbg = state;
  end

  assign result = result_q;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q     <= '0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (in_valid) begin
          // Both datapaths are loaded; only the selected one iterates
          f3_q    <= funct3;
          cnt     <= '0;
          acc     <= {{XLEN{1'b0}}, b_mag};
          mcand   <= a_mag;
          neg_q   <= a_neg ^ b_neg;
          rneg_q  <= a_neg;
          rem     <= '0;
          quo     <= a_mag;
          divisor <= b_mag;
          if (special) result_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
          else if (!funct3[2]) result_q <= fast_res;
`endif
        end
        ST_MUL: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (last) result_q <= mul_res;
        end
        ST_DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + CNT_W'(1);
          if (last) result_q <= div_res;
        end
        ST_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit
//   Directed bench for riscv_muldiv_unit (XLEN=32): multiply/divide vectors,
//   special cases, backpressure, flush and asynchronous reset mid-operation.
module tb_riscv_muldiv_unit;
  import riscv_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  riscv_muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Presents a request for one accept edge, then scrambles the inputs
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    funct3   = 3'($urandom_range(0, 7));
  endtask

  // Cycles counted with the accept edge as 1; bounded
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    @(negedge clk);
    check(tag, result, e);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_after"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    exp_q.push_back(exp);
    issue(f3, a, b);
    check({tag, "_busy"}, {31'd0, busy}, (exp_lat > 1) ? 32'd1 : 32'd0);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    consume(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_result",    result,             32'd0);

    // Multiply
    run_op("mul_7_m3",   F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",       F3_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu",     F3_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("mulhu",      F3_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 33);
    run_op("mulh_m2_m3", F3_MULH,   32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 33);
    run_op("mul_big",    F3_MUL,    32'h00010001, 32'h00010001, 32'h00020001, 33);

    // Divide
    run_op("div_m7_2",   F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_m7_2",   F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",       F3_DIVU,   32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33);
    run_op("remu",       F3_REMU,   32'hFFFFFFFF, 32'd2,        32'h00000001, 33);
    run_op("rem_7_m2",   F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33);

    // Special cases
    run_op("div_by0",    F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",    F3_REM,    32'd5,        32'd0,        32'd5,        1);
    run_op("divu_by0",   F3_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1);
    run_op("div_ovf",    F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",    F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Backpressure: result held, requests ignored while DONE
    exp_q.push_back(32'd15);
    issue(F3_MUL, 32'd3, 32'd5);
    wait_valid(lat);
    check("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      funct3   = F3_DIVU;
      op_a     = $urandom;
      op_b     = 32'd1;
      @(posedge clk);
      #1;
      check("bp_result",   result,              exp_q[0]);
      check("bp_in_ready", {31'd0, in_ready},   32'd0);
      check("bp_valid",    {31'd0, out_valid},  32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume("bp");

    // Flush at iteration 15 of a divide
    issue(F3_DIV, 32'd1000, 32'd7);
    repeat (15) @(posedge clk);
    #1;
    check("fl_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fl_in_ready",  {31'd0, in_ready},  32'd1);
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_busy",      {31'd0, busy},      32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("fl_no_output", 32'(seen), 32'd0);
    run_op("fl_mul_3x4", F3_MUL, 32'd3, 32'd4, 32'd12, 33);

    // Asynchronous reset in the middle of a multiply
    issue(F3_MULHU, 32'hDEADBEEF, 32'h12345678);
    repeat (10) @(posedge clk);
    #2;
    check("ar_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("ar_in_ready",  {31'd0, in_ready},  32'd1);
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_busy",      {31'd0, busy},      32'd0);
    check("ar_result",    result,             32'd0);
    check("ar_state",     {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    check("ar_no_output", 32'(seen), 32'd0);
    run_op("ar_divu", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
